// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder for a multicycle RV32I core
//
// Purpose: word-organised RAM behind a request/response handshake. One request
// is accepted in IDLE, held for LATENCY wait cycles, then committed on the edge
// entering RESP. Stores write selected byte lanes, and loads return sign- or
// zero-extended data.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword and word accesses return resp_err. When it is undefined, they are
// forced to natural alignment.
//
// Ports:
//   clk         clock; all state changes on its rising edge
//   clr         asynchronous active-high reset
//   req_valid   core presents a request
//   req_ready   request can be accepted (IDLE only)
//   req_write   1 = store, 0 = load/fetch
//   req_addr    byte address
//   req_wdata   store data (low bits for SB/SH)
//   req_func3   RV32I width/sign code
//   resp_valid  one-cycle response strobe
//   resp_rdata  extended load data, 0 for stores and errors
//   resp_err    request rejected, qualified by resp_valid
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  func3_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  accept, commit, we;
  logic                  cur_write;
  logic [31:0]           cur_addr, cur_wdata;
  logic [2:0]            cur_func3;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  ill, err_c;
  logic [31:0]           word, ld_data, wd;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [3:0]            be;
  logic                  unused_addr;

  assign accept = req_valid & ready_q;
  assign commit = (state_d == S_RESP) && (state_q != S_RESP);

  // With LATENCY = 0 the commit happens on the acceptance edge itself, so the
  // live request is used while in IDLE and the latched copy afterwards.
  assign cur_write   = (state_q == S_IDLE) ? req_write : write_q;
  assign cur_addr    = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata   = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign cur_func3   = (state_q == S_IDLE) ? req_func3 : func3_q;
  assign idx         = cur_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^cur_addr[31:ADDR_WIDTH+2];

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d   = LAT;
        state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. req_ready is registered so that it stays low while clr is high
  // and rises on the first edge after clr is released.
  always_comb begin
    ready_d    = (state_d == S_IDLE);
    req_ready  = ready_q;
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    rdata_d    = (commit && !cur_write && !err_c) ? ld_data : 32'd0;
    err_d      = commit & err_c;
  end

  // Access decode: alignment, legality, lane enables and load extension
  always_comb begin
    off = cur_addr[1:0];
    case (cur_func3[1:0])
      2'b01:   off = {cur_addr[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = cur_addr[1:0];
    endcase
    ill = cur_write ? (cur_func3[2] | (cur_func3[1:0] == 2'b11))
                    : ((cur_func3 == 3'b011) | (cur_func3[2:1] == 2'b11));
    word = mem[idx];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (cur_func3)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  ld_data = word;
      3'b100:  ld_data = {24'd0, byte_sel};
      3'b101:  ld_data = {16'd0, half_sel};
      default: ld_data = 32'd0;
    endcase
    case (cur_func3[1:0])
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = cur_wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis;
  always_comb begin
    case (cur_func3[1:0])
      2'b01:   mis = cur_addr[0];
      2'b10:   mis = |cur_addr[1:0];
      default: mis = 1'b0;
    endcase
    err_c = ill | mis;
  end
`else
  assign err_c = ill;
`endif

  // clr gates the write so that a reset coincident with the commit edge wins.
  assign we = commit & cur_write & ~err_c & ~clr;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  // Request latch and registered response
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        func3_q <= req_func3;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  func3 = '0;

  logic        v2 = 1'b0, v0 = 1'b0;
  logic        ready2, ready0, rv2, rv0, err2, err0;
  logic [31:0] rdata2, rdata0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
    .clk(clk), .clr(clr), .req_valid(v2), .req_ready(ready2),
    .req_write(write), .req_addr(addr), .req_wdata(wdata), .req_func3(func3),
    .resp_valid(rv2), .resp_rdata(rdata2), .resp_err(err2)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .clr(clr), .req_valid(v0), .req_ready(ready0),
    .req_write(write), .req_addr(addr), .req_wdata(wdata), .req_func3(func3),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sel = 1 targets the LATENCY=0 instance, sel = 0 the LATENCY=2 instance.
  task automatic req(input bit sel, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f3,
                     output logic [31:0] r, output logic e, output int l);
    @(negedge clk);
    chk("req_ready_before", sel ? ready0 : ready2, 32'd1);
    write = wr; addr = a; wdata = d; func3 = f3;
    if (sel) v0 = 1'b1; else v2 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v2 = 1'b0;
    l = -1; r = 'x; e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sel ? rv0 : rv2) begin
        l = i;
        r = sel ? rdata0 : rdata2;
        e = sel ? err0 : err2;
        break;
      end
    end
    if (l < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready2, 32'd0);
    chk("rst_valid", rv2, 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_err", err2, 32'd0);
    clr = 1'b0;
    #1 chk("rel_ready_noedge", ready2, 32'd0);
    @(negedge clk);
    chk("rel_ready_edge", ready2, 32'd1);

    // Store aborted by clr mid-WAIT must not commit
    req(0, 1, 32'h10, 32'h0BADF00D, 3'b010, rd, er, lat);
    @(negedge clk);
    write = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; func3 = 3'b010; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1 chk("clr_ready", ready2, 32'd0);
    chk("clr_valid", rv2, 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("clr_rel_ready", ready2, 32'd0);
    @(negedge clk);
    chk("clr_rel_ready1", ready2, 32'd1);
    req(0, 0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("abort_lw", rd, 32'h0BADF00D);

    // Word store/load, LATENCY=2
    req(0, 1, 32'h20, 32'h12345678, 3'b010, rd, er, lat);
    chk("sw_lat", lat, 32'd3);
    chk("sw_err", er, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    req(0, 0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    chk("lw_lat", lat, 32'd3);
    chk("lw_rdata", rd, 32'h12345678);
    chk("lw_err", er, 32'd0);

    // Byte/half lanes and extension
    req(0, 1, 32'h21, 32'h00000080, 3'b000, rd, er, lat);
    req(0, 0, 32'h21, 32'h0, 3'b000, rd, er, lat);
    chk("lb", rd, 32'hFFFFFF80);
    req(0, 0, 32'h21, 32'h0, 3'b100, rd, er, lat);
    chk("lbu", rd, 32'h00000080);
    req(0, 0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    chk("lw_after_sb", rd, 32'h12348078);
    req(0, 0, 32'h22, 32'h0, 3'b101, rd, er, lat);
    chk("lhu", rd, 32'h00001234);
    req(0, 0, 32'h20, 32'h0, 3'b001, rd, er, lat);
    chk("lh_neg", rd, 32'hFFFF8078);

    // Illegal func3
    req(0, 0, 32'h20, 32'h0, 3'b011, rd, er, lat);
    chk("ill_ld_err", er, 32'd1);
    chk("ill_ld_rdata", rd, 32'd0);
    req(0, 0, 32'h20, 32'h0, 3'b110, rd, er, lat);
    chk("ill_ld110_err", er, 32'd1);
    req(0, 1, 32'h20, 32'hFFFFFFFF, 3'b100, rd, er, lat);
    chk("ill_st_err", er, 32'd1);
    chk("ill_st_lat", lat, 32'd3);
    req(0, 0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    chk("ill_st_nowrite", rd, 32'h12348078);

    // Misaligned accesses
    req(0, 0, 32'h22, 32'h0, 3'b010, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
    chk("mis_lw_err", er, 32'd1);
    chk("mis_lw_rdata", rd, 32'd0);
`else
    chk("mis_lw_err", er, 32'd0);
    chk("mis_lw_rdata", rd, 32'h12348078);
`endif
    chk("mis_lw_lat", lat, 32'd3);
    req(0, 1, 32'h23, 32'h0000BEEF, 3'b001, rd, er, lat);
    req(0, 0, 32'h20, 32'h0, 3'b010, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
    chk("mis_sh_word", rd, 32'h12348078);
`else
    chk("mis_sh_word", rd, 32'hBEEF8078);
`endif

    // LATENCY=0: address wrap and throughput
    req(1, 1, 32'h1000, 32'hA5A5A5A5, 3'b010, rd, er, lat);
    chk("l0_sw_lat", lat, 32'd1);
    req(1, 0, 32'h0000, 32'h0, 3'b010, rd, er, lat);
    chk("l0_wrap_lw", rd, 32'hA5A5A5A5);
    chk("l0_lw_lat", lat, 32'd1);

    @(negedge clk);
    write = 1'b0; addr = 32'h0; func3 = 3'b010; v0 = 1'b1;
    @(negedge clk);
    chk("b2b_rv1", rv0, 32'd1);
    chk("b2b_rdy1", ready0, 32'd0);
    chk("b2b_rd1", rdata0, 32'hA5A5A5A5);
    @(negedge clk);
    chk("b2b_rv2", rv0, 32'd0);
    chk("b2b_rdy2", ready0, 32'd1);
    @(negedge clk);
    chk("b2b_rv3", rv0, 32'd1);
    chk("b2b_rdy3", ready0, 32'd0);
    @(negedge clk);
    chk("b2b_rv4", rv0, 32'd0);
    v0 = 1'b0;
    @(negedge clk);
    chk("b2b_idle", rv0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
